// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package : seg7_pkg
// Brief   : Shared types and constants for the 7-segment scan controller.
// Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } seg7_state_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high {g,f,e,d,c,b,a} glyphs; entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hex_decode
// Brief   : Combinational hex nibble to active-high {g..a} segment pattern.
// Rev     : 1.0  initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_PAT[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_ctrl
// Brief   : Four-digit time-multiplexed 7-segment scan controller; new values
//           are swapped in only at frame boundaries.
// Options : SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero digits 3..1.
// Rev     : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned GUARD      = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [15:0]           load_value,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam logic [31:0]           c_ON_LAST    = PRESCALE - 32'd1;
  localparam logic [31:0]           c_GUARD_LAST = GUARD - 32'd1;
  localparam bit                    c_GUARD_EN   = (GUARD != 0);
  localparam logic [6:0]            c_SEG_POL    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] c_DIG_POL    = ACTIVE_LOW ? 4'hF : 4'h0;

  seg7_state_e           r_state;
  seg7_state_e           w_state_nxt;
  logic [1:0]            r_idx;
  logic [1:0]            w_idx_nxt;
  logic [31:0]           r_cnt;
  logic [31:0]           w_cnt_nxt;
  logic                  w_frame_end;

  logic [15:0]           r_disp;
  logic [15:0]           r_pend;
  logic                  r_pend_full;
  logic                  w_pend_full_nxt;
  logic                  r_load_ready;
  logic                  w_accept;

  logic [3:0]            w_nibble;
  logic [6:0]            w_pat;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_dark;
  logic [6:0]            w_seg_ah;
  logic [NUM_DIGITS-1:0] w_dig_ah;

  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig_en;
  logic                  r_frame_done;

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_GUARD;
      r_idx   <= 2'd0;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 32'd1;
    w_frame_end = 1'b0;
    case (r_state)
      ST_GUARD: begin
        // With no guard time this state is only ever passed through after reset.
        if (!c_GUARD_EN || (r_cnt == c_GUARD_LAST)) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = 32'd0;
        end
      end
      ST_ON: begin
        if (r_cnt == c_ON_LAST) begin
          w_cnt_nxt   = 32'd0;
          w_state_nxt = c_GUARD_EN ? ST_GUARD : ST_ON;
          if (r_idx == 2'd3) begin
            w_idx_nxt   = 2'd0;
            w_frame_end = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_GUARD;
        w_idx_nxt   = 2'd0;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Load handshake and frame-boundary swap
  // --------------------------------------------------------------------------
  assign w_accept = load_valid && r_load_ready;

  always_comb begin
    w_pend_full_nxt = r_pend_full;
    if (w_frame_end && r_pend_full) begin
      w_pend_full_nxt = 1'b0;
    end
    if (w_accept) begin
      w_pend_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp       <= 16'h0000;
      r_pend       <= 16'h0000;
      r_pend_full  <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_pend_full  <= w_pend_full_nxt;
      r_load_ready <= !w_pend_full_nxt;
      // A value accepted in the boundary cycle lands in pending, never in r_disp.
      if (w_frame_end && r_pend_full) begin
        r_disp <= r_pend;
      end
      if (w_accept) begin
        r_pend <= load_value;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit drive
  // --------------------------------------------------------------------------
  assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_pat)
  );

  always_comb begin
    w_lz = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    w_lz[3] = (r_disp[15:12] == 4'h0);
    w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'h0);
    w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'h0);
`endif
  end

  assign w_dark   = blank_mask[r_idx] | w_lz[r_idx];
  assign w_seg_ah = (r_state == ST_ON) ? w_pat : SEG_OFF;
  assign w_dig_ah = ((r_state == ST_ON) && !w_dark) ? (4'b0001 << r_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg        <= SEG_OFF ^ c_SEG_POL;
      r_dig_en     <= c_DIG_POL;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_ah ^ c_SEG_POL;
      r_dig_en     <= w_dig_ah ^ c_DIG_POL;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign dig_en     = r_dig_en;
  assign frame_done = r_frame_done;
  assign load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_ctrl
// Brief   : Scoreboard bench for seg7_scan_ctrl (PRESCALE=4, GUARD=1,
//           ACTIVE_LOW=1); honours SEG7_LEADING_ZERO_BLANK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int P     = 4;
  localparam int G     = 1;
  localparam int SLOT  = P + G;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_value = 16'h0000;
  logic [3:0]  blank_mask = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .PRESCALE   (P),
    .GUARD      (G),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .blank_mask (blank_mask),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_pat(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic lz_dark(input logic [15:0] v, input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int k = d; k < 4; k++) begin
      if (v[4*k +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
`else
    return (v == 16'hFFFF) && (d > 4);
`endif
  endfunction

  // Scoreboard: accepted values queue up and are consumed at each frame_done.
  logic [15:0] sb_q[$];
  logic [15:0] exp_disp = 16'h0000;
  int          ph = 0;
  bit          started = 1'b0;
  logic        vld_prev = 1'b0;
  logic        rdy_prev = 1'b0;
  logic [15:0] val_prev = 16'h0000;
  logic [3:0]  bm_prev = 4'h0;

  always @(negedge clk) begin : mon
    int         t;
    int         d;
    logic       dark;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    if (reset) begin
      started  = 1'b0;
      ph       = 0;
      sb_q.delete();
      exp_disp = 16'h0000;
      vld_prev = 1'b0;
      rdy_prev = 1'b0;
      bm_prev  = blank_mask;
    end else begin
      if (!started) begin
        started = 1'b1;
        ph      = 0;
      end else begin
        ph++;
      end
      chk("frame_done", 32'(frame_done), 32'(ph == FRAME));
      t     = ph - 1;
      d     = (t >= 0) ? t / SLOT : 0;
      e_dig = 4'hF;
      e_seg = 7'h7F;
      if (ph >= 1 && ph <= FRAME && (t % SLOT) >= G) begin
        dark  = bm_prev[d] | lz_dark(exp_disp, d);
        e_dig = dark ? 4'hF : ~(4'b0001 << d);
        e_seg = ~exp_pat(exp_disp[4*d +: 4]);
      end
      chk("dig_en", 32'(dig_en), 32'(e_dig));
      chk("seg", 32'(seg), 32'(e_seg));
      if (frame_done) begin
        if (sb_q.size() > 0) exp_disp = sb_q.pop_front();
        ph = 0;
      end
      if (vld_prev && rdy_prev) sb_q.push_back(val_prev);
      chk("load_ready", 32'(load_ready), 32'(sb_q.size() == 0));
      vld_prev = load_valid;
      rdy_prev = load_ready;
      val_prev = load_value;
      bm_prev  = blank_mask;
    end
  end

  // Drivers start and end at posedge+1 so inputs never move near an edge.
  task automatic load(input logic [15:0] v);
    load_valid = 1'b1;
    load_value = v;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        return;
      end
    end
    chk("load_timeout", 32'(load_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int f = 0; f < n; f++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
        @(negedge clk);
        if (frame_done) seen = 1'b1;
      end
      if (!seen) chk("frame_timeout", 32'(frame_done), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input int n);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      #1;
      if (ph == n) return;
    end
    chk("phase_timeout", 32'(ph), 32'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dig_en", 32'(dig_en), 32'hF);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    reset = 1'b0;

    load(16'h1234);
    wait_frames(2);

    load(16'hAAAA);
    load(16'h5555);
    wait_frames(3);

    blank_mask = 4'b0010;
    wait_frames(2);
    blank_mask = 4'b0000;

    wait_ph(18);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_value = 16'hC0DE;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_frames(3);

    load(16'h0050);
    wait_frames(2);
    load(16'h0000);
    wait_frames(2);
    load(16'h0A07);
    wait_frames(2);

    for (int r = 0; r < 6; r++) begin
      load(16'($urandom));
      blank_mask = 4'($urandom);
      wait_frames(1);
    end
    blank_mask = 4'h0;
    wait_frames(1);

    // Async reset while digit 1 is lit and a value is still pending.
    load(16'h9876);
    wait_frames(1);
    wait_ph(7);
    @(posedge clk);
    #1;
    load_valid = 1'b1;
    load_value = 16'hBEEF;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dig_en", 32'(dig_en), 32'hF);
    chk("async_rst_frame_done", 32'(frame_done), 32'd0);
    chk("async_rst_load_ready", 32'(load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
